// File: rtl/mem_trace_fifo_if.sv
// Write-capture and record-output handshake bundle for mem_trace_fifo.
// The master drives processor writes and consumer ready; the slave (the FIFO) returns head records.
interface mem_trace_fifo_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 24
);
    logic                     cap_en;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [ADDR_W+DATA_W-1:0] rec_data;
    logic                     rec_valid;
    logic                     rec_ready;

    modport master (
        output cap_en, wr_en, wr_addr, wr_data, rec_ready,
        input  rec_data, rec_valid
    );

    modport slave (
        input  cap_en, wr_en, wr_addr, wr_data, rec_ready,
        output rec_data, rec_valid
    );
endinterface

// File: rtl/mem_trace_fifo.sv
// Capture buffer for data-memory write records: qualifies {addr,data} writes, queues them in a
// first-word fall-through FIFO and counts records lost to a full FIFO.
module mem_trace_fifo #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 24,
    parameter int DEPTH       = 16,
    parameter int FILTER_ZERO = 1,
    parameter int CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    mem_trace_fifo_if.slave             bus,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      level,
    output logic [CNT_W-1:0]            drop_count,
    output logic                        overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int REC_W = ADDR_W + DATA_W;

    logic [REC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic [CNT_W-1:0] drop_reg;
    logic             overflow_reg;

    logic keep;
    logic qualify;
    logic pop;
    logic push;
    logic drop;

    // Zero filtering is a build-time choice, so it is resolved structurally.
    generate
        if (FILTER_ZERO != 0) begin : g_filter
            assign keep = (bus.wr_addr != '0) && (bus.wr_data != '0);
        end else begin : g_nofilter
            assign keep = 1'b1;
        end
    endgenerate

    assign full    = (level_reg == LVL_W'(DEPTH));
    assign empty   = (level_reg == '0);
    assign qualify = bus.cap_en & bus.wr_en & keep;
    assign pop     = !empty & bus.rec_ready;
    assign push    = qualify & (!full | pop);
    assign drop    = qualify & full & !pop;

    assign bus.rec_valid = !empty;
    assign bus.rec_data  = mem[rd_ptr_reg];
    assign level         = level_reg;
    assign drop_count    = drop_reg;
    assign overflow      = overflow_reg;

    // Storage needs no reset: only slots between the pointers are ever observed.
    always_ff @(posedge clk) begin
        if (reset && !clear && push) begin
            mem[wr_ptr_reg] <= {bus.wr_addr, bus.wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            drop_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
            if (drop) begin
                overflow_reg <= 1'b1;
                if (drop_reg != '1) begin
                    drop_reg <= drop_reg + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_trace_fifo.sv
// Self-checking bench for mem_trace_fifo: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_mem_trace_fifo;
    logic clk = 1'b0;
    logic reset;
    logic clear_a, clear_b;

    always #5 clk = ~clk;

    mem_trace_fifo_if #(.ADDR_W(16), .DATA_W(24)) bus_a ();
    mem_trace_fifo_if #(.ADDR_W(16), .DATA_W(24)) bus_b ();

    logic        full_a, empty_a, ovf_a;
    logic [4:0]  level_a;
    logic [15:0] drop_a;
    logic        full_b, empty_b, ovf_b;
    logic [2:0]  level_b;
    logic [1:0]  drop_b;

    mem_trace_fifo #(.ADDR_W(16), .DATA_W(24), .DEPTH(16), .FILTER_ZERO(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .clear(clear_a), .bus(bus_a.slave),
        .full(full_a), .empty(empty_a), .level(level_a),
        .drop_count(drop_a), .overflow(ovf_a)
    );

    mem_trace_fifo #(.ADDR_W(16), .DATA_W(24), .DEPTH(4), .FILTER_ZERO(0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .clear(clear_b), .bus(bus_b.slave),
        .full(full_b), .empty(empty_b), .level(level_b),
        .drop_count(drop_b), .overflow(ovf_b)
    );

    int errors = 0;
    int checks = 0;

    // Reference model for dut_a: a queue of records plus drop statistics.
    logic [39:0] q[$];
    int          m_drop = 0;
    bit          m_ovf  = 0;

    typedef struct {
        bit          rst_n;
        bit          clr;
        bit          cap;
        bit          wen;
        logic [15:0] a;
        logic [23:0] d;
        bit          rdy;
        int          e_level;
        bit          e_valid;
        logic [39:0] e_head;
        int          e_drop;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_a(input bit cap, input bit wen, input logic [15:0] a,
                         input logic [23:0] d, input bit rdy);
        bus_a.cap_en    = cap;
        bus_a.wr_en     = wen;
        bus_a.wr_addr   = a;
        bus_a.wr_data   = d;
        bus_a.rec_ready = rdy;
    endtask

    // Advance one clock; the model applies the same cycle's rules before the edge.
    task automatic tick();
        bit qual, popping, is_full;
        qual = bus_a.cap_en && bus_a.wr_en && bus_a.wr_addr != 0 && bus_a.wr_data != 0;
        if (!reset || clear_a) begin
            q.delete();
            m_drop = 0;
            m_ovf  = 0;
        end else begin
            popping = (q.size() > 0) && bus_a.rec_ready;
            is_full = (q.size() == 16);
            if (qual && is_full && !popping) begin
                if (m_drop < 65535) m_drop++;
                m_ovf = 1;
            end
            if (popping) void'(q.pop_front());
            if (qual && !(is_full && !popping)) q.push_back({bus_a.wr_addr, bus_a.wr_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [23:0] d, input bit rdy);
        set_a(1, 1, a, d, rdy);
        tick();
    endtask

    task automatic idle(input bit rdy);
        set_a(0, 0, 16'h0, 24'h0, rdy);
        tick();
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".level"}, 64'(level_a), 64'(q.size()));
        chk({tag, ".empty"}, 64'(empty_a), 64'(q.size() == 0));
        chk({tag, ".full"},  64'(full_a),  64'(q.size() == 16));
        chk({tag, ".valid"}, 64'(bus_a.rec_valid), 64'(q.size() != 0));
        if (q.size() != 0) chk({tag, ".head"}, 64'(bus_a.rec_data), 64'(q[0]));
        chk({tag, ".drop"}, 64'(drop_a), 64'(m_drop));
        chk({tag, ".ovf"},  64'(ovf_a),  64'(m_ovf));
    endtask

    initial begin
        reset = 1'b0; clear_a = 1'b0; clear_b = 1'b0;
        set_a(0, 0, 0, 0, 0);
        bus_b.cap_en = 0; bus_b.wr_en = 0; bus_b.wr_addr = 0; bus_b.wr_data = 0; bus_b.rec_ready = 0;

        // Vector table: filtering, ignored writes, then push-5 / pop-5 in order.
        tbl.push_back('{0, 0, 0, 0, 16'h0000, 24'h000000, 0, 0, 0, 40'h0, 0});
        tbl.push_back('{1, 0, 1, 1, 16'h0010, 24'h000001, 0, 1, 1, 40'h0010_000001, 0});
        tbl.push_back('{1, 0, 1, 1, 16'h0000, 24'h000005, 0, 1, 1, 40'h0010_000001, 0});
        tbl.push_back('{1, 0, 1, 1, 16'h0020, 24'h000000, 0, 1, 1, 40'h0010_000001, 0});
        tbl.push_back('{1, 0, 0, 1, 16'h0030, 24'h000007, 0, 1, 1, 40'h0010_000001, 0});
        tbl.push_back('{1, 0, 1, 0, 16'h0040, 24'h000008, 0, 1, 1, 40'h0010_000001, 0});
        tbl.push_back('{1, 0, 0, 0, 16'h0000, 24'h000000, 1, 0, 0, 40'h0, 0});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{1, 0, 1, 1, 16'(i + 1), 24'(10 + i), 0, i + 1, 1, 40'h0001_00000A, 0});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{1, 0, 0, 0, 16'h0, 24'h0, 1, 4 - i, (i < 4), {16'(i + 2), 24'(11 + i)}, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst_n;
            clear_a = tbl[i].clr;
            set_a(tbl[i].cap, tbl[i].wen, tbl[i].a, tbl[i].d, tbl[i].rdy);
            tick();
            chk($sformatf("vec%0d.level", i), 64'(level_a), 64'(tbl[i].e_level));
            chk($sformatf("vec%0d.valid", i), 64'(bus_a.rec_valid), 64'(tbl[i].e_valid));
            chk($sformatf("vec%0d.empty", i), 64'(empty_a), 64'(tbl[i].e_level == 0));
            chk($sformatf("vec%0d.drop", i), 64'(drop_a), 64'(tbl[i].e_drop));
            if (tbl[i].e_valid) chk($sformatf("vec%0d.head", i), 64'(bus_a.rec_data), 64'(tbl[i].e_head));
        end
        if (tbl.size() > 0) chk("vec.reset_full", 64'(full_a), 64'(0));

        // Overfill by two, then flush.
        clear_a = 1; idle(0); clear_a = 0;
        for (int i = 0; i < 18; i++) begin
            wr(16'(i + 1), 24'(i + 'h100), 0);
            if (i == 14) chk("fill.not_full15", 64'(full_a), 64'(0));
            if (i == 15) chk("fill.full16", 64'(full_a), 64'(1));
        end
        chk("fill.level", 64'(level_a), 64'(16));
        chk("fill.drop", 64'(drop_a), 64'(2));
        chk("fill.ovf", 64'(ovf_a), 64'(1));
        chk("fill.head", 64'(bus_a.rec_data), {24'h0, 16'h1, 24'h100});
        clear_a = 1; wr(16'h0077, 24'h000077, 1); clear_a = 0;
        chk("clear.level", 64'(level_a), 64'(0));
        chk("clear.drop", 64'(drop_a), 64'(0));
        chk("clear.ovf", 64'(ovf_a), 64'(0));
        chk("clear.empty", 64'(empty_a), 64'(1));

        // Full FIFO: write and pop in the same cycle.
        for (int i = 0; i < 16; i++) wr(16'(i + 1), 24'(i + 'h100), 0);
        wr(16'hBEEF, 24'hCAFE01, 1);
        chk("fullpp.level", 64'(level_a), 64'(16));
        chk("fullpp.head", 64'(bus_a.rec_data), {24'h0, 16'h2, 24'h101});
        chk("fullpp.drop", 64'(drop_a), 64'(0));
        for (int k = 2; k <= 16; k++) begin
            chk($sformatf("fullpp.drain%0d", k), 64'(bus_a.rec_data), {24'h0, 16'(k), 24'(k - 1 + 'h100)});
            idle(1);
        end
        chk("fullpp.tail", 64'(bus_a.rec_data), {24'h0, 16'hBEEF, 24'hCAFE01});
        idle(1);
        chk("fullpp.empty", 64'(empty_a), 64'(1));

        // Pointer wrap: fill 10, drain 10, fill 12, drain 12.
        clear_a = 1; idle(0); clear_a = 0;
        for (int i = 0; i < 10; i++) wr(16'(i + 1), 24'(i + 'h300), 0);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("wrap.a%0d", i), 64'(bus_a.rec_data), {24'h0, 16'(i + 1), 24'(i + 'h300)});
            idle(1);
        end
        for (int i = 0; i < 12; i++) begin
            wr(16'(i + 'h40), 24'(i + 'h200), 0);
            chk($sformatf("wrap.lvl_up%0d", i), 64'(level_a), 64'(i + 1));
        end
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("wrap.b%0d", i), 64'(bus_a.rec_data), {24'h0, 16'(i + 'h40), 24'(i + 'h200)});
            idle(1);
            chk($sformatf("wrap.lvl_dn%0d", i), 64'(level_a), 64'(11 - i));
        end

        // Mid-stream reset with a simultaneous write.
        for (int i = 0; i < 7; i++) wr(16'(i + 1), 24'(i + 1), 0);
        reset = 0; wr(16'h0099, 24'h000099, 0); reset = 1;
        chk("rst.level", 64'(level_a), 64'(0));
        chk("rst.empty", 64'(empty_a), 64'(1));
        chk("rst.valid", 64'(bus_a.rec_valid), 64'(0));
        chk("rst.drop", 64'(drop_a), 64'(0));

        // Small counter saturates; zero records are kept with filtering off.
        bus_b.cap_en = 1; bus_b.wr_en = 1; bus_b.rec_ready = 0;
        for (int i = 0; i < 9; i++) begin
            bus_b.wr_addr = 16'h0; bus_b.wr_data = 24'(i);
            tick();
            if (i == 3) chk("sat.full", 64'(full_b), 64'(1));
            if (i == 5) chk("sat.drop2", 64'(drop_b), 64'(2));
        end
        bus_b.cap_en = 0; bus_b.wr_en = 0;
        chk("sat.drop", 64'(drop_b), 64'(3));
        chk("sat.ovf", 64'(ovf_b), 64'(1));
        chk("sat.level", 64'(level_b), 64'(4));
        chk("sat.head", 64'(bus_b.rec_data), 64'(0));
        clear_b = 1; tick(); clear_b = 0;
        chk("sat.clear", 64'(drop_b), 64'(0));

        // Randomized traffic against the model, with alternating drain pressure.
        for (int i = 0; i < 3000; i++) begin
            bit rdy_bias;
            rdy_bias = ((i / 200) % 2) == 1;
            set_a(($urandom % 8) != 0, $urandom % 2,
                  (($urandom % 5) == 0) ? 16'h0 : 16'($urandom),
                  (($urandom % 5) == 0) ? 24'h0 : 24'($urandom),
                  rdy_bias ? (($urandom % 5) != 0) : (($urandom % 5) == 0));
            clear_a = (($urandom % 128) == 0);
            reset   = (($urandom % 300) != 0);
            tick();
            check_model($sformatf("rnd%0d", i));
        end
        reset = 1; clear_a = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
